// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg -- shared types and constants for the alu_sched scheduler.
//   state_t    : scheduler FSM states (IDLE, EXEC, RESP)
//   OP_*       : 4-bit ALU opcodes understood by the alu module; codes 8..15
//                are not listed here and return operand A.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_ABSDIFF = 4'd1;
  localparam logic [3:0] OP_GT      = 4'd2;
  localparam logic [3:0] OP_AND     = 4'd3;
  localparam logic [3:0] OP_OR      = 4'd4;
  localparam logic [3:0] OP_XOR     = 4'd5;
  localparam logic [3:0] OP_PASSA   = 4'd6;
  localparam logic [3:0] OP_PASSB   = 4'd7;

endpackage

// File: rtl/alu.sv
// alu -- purely combinational shared ALU, operands and result WIDTH+1 bits.
//   a, b : operands
//   sel  : opcode (see alu_sched_pkg OP_*); 8..15 return a
//   x    : result (add wraps modulo 2^(WIDTH+1), GT returns 0 or 1)
module alu
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic [3:0]     sel,
  output logic [WIDTH:0] x
);

  // Opcode decode; anything outside the named codes falls through to pass-A.
  always_comb begin
    x = a;
    case (sel)
      OP_ADD:     x = a + b;
      OP_ABSDIFF: x = (a > b) ? (a - b) : (b - a);
      OP_GT:      x = {{WIDTH{1'b0}}, (a > b)};
      OP_AND:     x = a & b;
      OP_OR:      x = a | b;
      OP_XOR:     x = a ^ b;
      OP_PASSA:   x = a;
      OP_PASSB:   x = b;
      default:    x = a;
    endcase
  end

endmodule

// File: rtl/alu_sched_rr.sv
// alu_sched_rr -- combinational round-robin picker.
//   valid : request vector
//   ptr   : index of the highest-priority requester this cycle
//   grant : one-hot winner (all zero when nothing is valid)
module alu_sched_rr #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         valid,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant
);

  logic [NREQ-1:0] hi_mask;
  logic [NREQ-1:0] masked;

  // Requesters at or above ptr get first pick; if none of them is valid the
  // search wraps to the lowest valid index. x & (~x + 1) isolates the lowest
  // set bit, which gives the one-hot winner without a priority loop.
  always_comb begin
    hi_mask = ~((NREQ'(1) << ptr) - NREQ'(1));
    masked  = valid & hi_mask;
    if (|masked) begin
      grant = masked & (~masked + NREQ'(1));
    end else begin
      grant = valid & (~valid + NREQ'(1));
    end
  end

endmodule

// File: rtl/alu_sched.sv
// alu_sched -- round-robin scheduler sharing one ALU among NREQ requesters.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (ready only for the winner in IDLE)
//   req_a, req_b, req_sel: per-requester operands and opcode
//   rsp_valid/rsp_ready  : result handshake
//   rsp_x, rsp_id        : result and the index of the requester that issued it
//   ops_done             : completed-response counter, saturating; present only
//                          when ALU_SCHED_STATS_EN is defined
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int NREQ  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NREQ-1:0]               req_valid,
  output logic [NREQ-1:0]               req_ready,
  input  logic [NREQ-1:0][WIDTH:0]      req_a,
  input  logic [NREQ-1:0][WIDTH:0]      req_b,
  input  logic [NREQ-1:0][3:0]          req_sel,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [WIDTH:0]                rsp_x,
  output logic [$clog2(NREQ)-1:0]       rsp_id
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [15:0]                   ops_done
`endif
);

  localparam int IW = $clog2(NREQ);

  state_t          state, next_state;
  logic [IW-1:0]   ptr, next_ptr;
  logic [NREQ-1:0] grant;
  logic            accept;
  logic [IW-1:0]   win_id;
  logic [WIDTH:0]  win_a, win_b;
  logic [3:0]      win_sel;
  logic [WIDTH:0]  lat_a, lat_b;
  logic [3:0]      lat_sel;
  logic [IW-1:0]   lat_id;
  logic [WIDTH:0]  alu_x;

  alu_sched_rr #(.NREQ(NREQ)) u_rr (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  alu #(.WIDTH(WIDTH)) u_alu (
    .a   (lat_a),
    .b   (lat_b),
    .sel (lat_sel),
    .x   (alu_x)
  );

  // A grant is only a transfer while IDLE; the winner is always valid.
  assign accept = (state == IDLE) && (|grant);

  // Convert the one-hot grant into an index and pick that requester's fields.
  always_comb begin
    win_id  = '0;
    win_a   = '0;
    win_b   = '0;
    win_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_id  = IW'(i);
        win_a   = req_a[i];
        win_b   = req_b[i];
        win_sel = req_sel[i];
      end
    end
    next_ptr = (win_id == IW'(NREQ - 1)) ? '0 : win_id + IW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state: one accept, one compute cycle, then hold until consumed.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs: nothing is accepted while an operation is in flight.
  always_comb begin
    req_ready = (state == IDLE) ? grant : '0;
    rsp_valid = (state == RESP);
  end

  // Operand latch, pointer advance and result register. The result is only
  // written in EXEC, so it holds through RESP regardless of rsp_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      lat_a   <= '0;
      lat_b   <= '0;
      lat_sel <= '0;
      lat_id  <= '0;
      rsp_x   <= '0;
      rsp_id  <= '0;
    end else begin
      if (accept) begin
        ptr     <= next_ptr;
        lat_a   <= win_a;
        lat_b   <= win_b;
        lat_sel <= win_sel;
        lat_id  <= win_id;
      end
      if (state == EXEC) begin
        rsp_x  <= alu_x;
        rsp_id <= lat_id;
      end
    end
  end

`ifdef ALU_SCHED_STATS_EN
  // Completed-response counter, sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_done <= '0;
    end else if (rsp_valid && rsp_ready && (ops_done != 16'hFFFF)) begin
      ops_done <= ops_done + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_sched.sv
// tb_alu_sched -- directed bench for alu_sched (WIDTH=5, NREQ=4) with a
// reference model of the scheduler checked every cycle. Define
// ALU_SCHED_STATS_EN to also cover the ops_done counter.
module tb_alu_sched;

  localparam int WIDTH = 5;
  localparam int NREQ  = 4;

  logic                    clk;
  logic                    rst_n;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ-1:0]         req_ready;
  logic [NREQ-1:0][WIDTH:0] req_a;
  logic [NREQ-1:0][WIDTH:0] req_b;
  logic [NREQ-1:0][3:0]    req_sel;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [WIDTH:0]          rsp_x;
  logic [1:0]              rsp_id;
`ifdef ALU_SCHED_STATS_EN
  logic [15:0]             ops_done;
`endif

  int vectors;
  int miscompares;
  int cyc;
  int log_id[$];
  int log_cyc[$];

  alu_sched #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_x     (rsp_x),
    .rsp_id    (rsp_id)
`ifdef ALU_SCHED_STATS_EN
    ,
    .ops_done  (ops_done)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference arithmetic on plain integers.
  function automatic int aluRef(input int a, input int b, input int op);
    int r;
    case (op)
      0:       r = (a + b) % 64;
      1:       r = (a > b) ? a - b : b - a;
      2:       r = (a > b) ? 1 : 0;
      3:       r = a & b;
      4:       r = a | b;
      5:       r = a ^ b;
      6:       r = a;
      7:       r = b;
      default: r = a;
    endcase
    return r;
  endfunction

  // First valid requester scanning upward from p, wrapping; -1 if none.
  function automatic int rrPick(input logic [NREQ-1:0] v, input int p);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (p + k) % NREQ;
      if (v[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  // Model: the unit is either free, or busy with an operation accepted
  // m_age cycles ago; the result is visible from one cycle after acceptance
  // until it is consumed.
  bit m_busy;
  int m_age;
  int m_ptr;
  int m_win;
  int m_pend_x;
  int m_pend_id;
  int m_rsp_x;
  int m_rsp_id;
  int m_ops;

  always_comb m_win = rrPick(req_valid, m_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy    <= 1'b0;
      m_age     <= 0;
      m_ptr     <= 0;
      m_pend_x  <= 0;
      m_pend_id <= 0;
      m_rsp_x   <= 0;
      m_rsp_id  <= 0;
      m_ops     <= 0;
    end else if (!m_busy) begin
      if (m_win >= 0) begin
        m_busy    <= 1'b1;
        m_age     <= 0;
        m_pend_x  <= aluRef(int'(req_a[m_win[1:0]]), int'(req_b[m_win[1:0]]),
                            int'(req_sel[m_win[1:0]]));
        m_pend_id <= m_win;
        m_ptr     <= (m_win + 1) % NREQ;
      end
    end else if (m_age == 0) begin
      m_age    <= 1;
      m_rsp_x  <= m_pend_x;
      m_rsp_id <= m_pend_id;
    end else if (rsp_ready) begin
      m_busy <= 1'b0;
      if (m_ops < 65535) m_ops <= m_ops + 1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accept seen on the DUT's own handshake.
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        log_id.push_back(i);
        log_cyc.push_back(cyc);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] expReady();
    if (m_busy || m_win < 0) return 32'd0;
    return 32'd1 << m_win;
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    checkOutput("req_ready", 32'(req_ready), expReady());
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age == 1));
    checkOutput("rsp_x", 32'(rsp_x), m_rsp_x);
    checkOutput("rsp_id", 32'(rsp_id), m_rsp_id);
`ifdef ALU_SCHED_STATS_EN
    checkOutput("ops_done", 32'(ops_done), m_ops);
`endif
  end

  // Issue one operation from an otherwise idle bench and check its result.
  // Called at 2 time units after a rising edge; returns at the same phase.
  task automatic applyStimulus(input int id, input int a, input int b, input int op,
                               input int exp_x, input string name);
    int n;
    req_valid = '0;
    req_a[id[1:0]]   = 6'(a);
    req_b[id[1:0]]   = 6'(b);
    req_sel[id[1:0]] = 4'(op);
    req_valid[id[1:0]] = 1'b1;
    rsp_ready = 1'b1;
    n = 0;
    #1;
    while (req_ready[id[1:0]] !== 1'b1 && n < 10) begin
      @(posedge clk); #2;
      n++;
    end
    checkOutput({name, "_wait"}, 32'(n), 32'd0);
    if (n < 10) begin
      @(posedge clk); #2;
      req_valid = '0;
      checkOutput({name, "_exec"}, 32'(rsp_valid), 32'd0);
      @(posedge clk); #2;
      checkOutput({name, "_valid"}, 32'(rsp_valid), 32'd1);
      checkOutput({name, "_x"}, 32'(rsp_x), 32'(exp_x));
      checkOutput({name, "_id"}, 32'(rsp_id), 32'(id));
      @(posedge clk); #2;
    end else begin
      req_valid = '0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_sel = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_x", 32'(rsp_x), 32'd0);
    rst_n = 1'b1;

    // Single operations, literal results.
    applyStimulus(0, 20, 7, 0, 27, "add");
    applyStimulus(1, 3, 10, 1, 7, "absdiff");
    applyStimulus(2, 63, 1, 0, 0, "addwrap");
    applyStimulus(3, 5, 9, 2, 0, "gt0");
    applyStimulus(0, 9, 5, 2, 1, "gt1");
    applyStimulus(1, 12, 10, 3, 8, "and");
    applyStimulus(2, 12, 10, 4, 14, "or");
    applyStimulus(0, 12, 10, 5, 6, "xor");
    applyStimulus(1, 33, 10, 6, 33, "passa");
    applyStimulus(2, 33, 10, 7, 10, "passb");
    applyStimulus(3, 41, 2, 12, 41, "op12");

    // All requesters valid: round-robin order and issue spacing.
    log_id.delete();
    log_cyc.delete();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i] = 6'(i + 1);
      req_b[i] = 6'(2 * i);
      req_sel[i] = 4'(i);
    end
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    req_valid = '0;
    repeat (4) @(posedge clk);
    #2;
    checkOutput("rr_count", 32'(log_id.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < log_id.size()) begin
        checkOutput($sformatf("rr_order%0d", k), 32'(log_id[k]), 32'(k % NREQ));
        if (k > 0)
          checkOutput($sformatf("rr_gap%0d", k), 32'(log_cyc[k] - log_cyc[k-1]), 32'd3);
      end
    end

    // Back-pressure: result held, nothing accepted.
    req_a[1] = 6'd11;
    req_b[1] = 6'd4;
    req_sel[1] = 4'd0;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    #1;
    checkOutput("hold_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("hold_valid%0d", k), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("hold_x%0d", k), 32'(rsp_x), 32'd15);
      checkOutput($sformatf("hold_id%0d", k), 32'(rsp_id), 32'd1);
      checkOutput($sformatf("hold_ready%0d", k), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #2;
    checkOutput("hold_release", 32'(rsp_valid), 32'd0);

    // Reset while an operation is executing.
    req_a[2] = 6'd1;
    req_b[2] = 6'd1;
    req_sel[2] = 4'd0;
    req_valid = 4'b0100;
    @(posedge clk); #2;
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_exec_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_exec_x", 32'(rsp_x), 32'd0);
    rst_n = 1'b1;
    req_valid = 4'b1111;
    #1;
    checkOutput("rst_ptr_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #2;
    checkOutput("rst_no_rsp", 32'(rsp_valid), 32'd0);
    req_valid = '0;
    repeat (4) @(posedge clk);
    #2;

`ifdef ALU_SCHED_STATS_EN
    // Handshake counter.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    checkOutput("stats_reset0", 32'(ops_done), 32'd0);
    @(posedge clk); #2;
    applyStimulus(0, 1, 2, 0, 3, "st1");
    applyStimulus(1, 4, 2, 0, 6, "st2");
    applyStimulus(2, 7, 2, 1, 5, "st3");
    checkOutput("stats_three", 32'(ops_done), 32'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("stats_cleared", 32'(ops_done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
ALU_SCHED -- requirements
Module: alu_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, where operands and result are WIDTH+1 bits.
REQ-002 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, NREQ bits: per-requester request valid.
REQ-006 The block SHALL have port req_ready, output, NREQ bits: per-requester accept.
REQ-007 The block SHALL have port req_a, input, NREQ x (WIDTH+1) bits: per-requester operand A.
REQ-008 The block SHALL have port req_b, input, NREQ x (WIDTH+1) bits: per-requester operand B.
REQ-009 The block SHALL have port req_sel, input, NREQ x 4 bits: per-requester ALU opcode.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: result valid.
REQ-011 The block SHALL have port rsp_ready, input, 1 bit: consumer accepts the result.
REQ-012 The block SHALL have port rsp_x, output, WIDTH+1 bits: the result.
REQ-013 The block SHALL have port rsp_id, output, $clog2(NREQ) bits: index of the requester that issued the result.

Function
REQ-014 The FSM SHALL have three states: IDLE, EXEC and RESP; it sequences one shared ALU datapath.
REQ-015 In IDLE, req_ready[i] SHALL be 1 only for the round-robin winner i among asserted req_valid bits, and 0 elsewhere.
REQ-016 In EXEC and RESP, all req_ready bits SHALL be 0.
REQ-017 Round-robin winner selection:
- Search starts at pointer ptr and wraps modulo NREQ.
- After a grant to i, ptr SHALL become (i+1) mod NREQ.
- ptr SHALL be unchanged when no grant occurs.
REQ-018 On the IDLE transfer (req_valid[i] & req_ready[i]), the block SHALL latch a, b, sel and id=i, then go to EXEC.
REQ-019 In EXEC, the ALU SHALL be driven from the latched operands, and its output SHALL be registered into rsp_x and rsp_id; next state RESP.
REQ-020 In RESP, rsp_valid SHALL be 1; on rsp_ready the FSM SHALL go to IDLE, with no new accept in that cycle.
REQ-021 Latency from accept edge to rsp_valid SHALL be 2 cycles; minimum issue interval SHALL be 3 cycles.
REQ-022 rsp_x and rsp_id SHALL hold stable while rsp_valid & !rsp_ready.
REQ-023 ALU results SHALL be taken unmodified:
- Add wraps modulo 2^(WIDTH+1).
- Opcodes 8..15 yield A.
- The scheduler SHALL NOT filter opcodes.
REQ-024 A requester that drops req_valid before being granted SHALL lose nothing; no request state is stored before acceptance.

Reset
REQ-025 rst_n low SHALL immediately force:
- state IDLE
- ptr 0
- rsp_valid 0, rsp_x 0, rsp_id 0
- latched operands 0
- stats counter 0
REQ-026 Reset in EXEC or RESP SHALL discard the in-flight operation with no response produced.

Configuration
REQ-027 With macro ALU_SCHED_STATS_EN defined, output ops_done (16 bits) SHALL count rsp_valid & rsp_ready handshakes, saturating at 16'hFFFF.
REQ-028 Without ALU_SCHED_STATS_EN, the ops_done port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 Package alu_sched_pkg SHALL hold:
- the FSM state enum (IDLE, EXEC, RESP)
- opcode localparams OP_ADD=0, OP_ABSDIFF=1, OP_GT=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_PASSA=6, OP_PASSB=7
REQ-030 Round-robin selection SHALL be one sub-module, alu_sched_rr (inputs: valid vector, ptr; output: one-hot grant).
REQ-031 The datapath SHALL be one instance of the team's alu module, with WIDTH passed through.

Verification (WIDTH=5, NREQ=4)
REQ-032 Reset, then req_valid[0], a=20, b=7, sel=0 -> accepted in 1 cycle; 2 cycles later rsp_valid=1, rsp_x=27, rsp_id=0.
REQ-033 req1 sel=1, a=3, b=10 -> rsp_x=7; req2 sel=0, a=63, b=1 -> rsp_x=0 (wrap).
REQ-034 All four req_valid held high and rsp_ready=1 -> grant order 0,1,2,3,0, with a new accept every 3 cycles.
REQ-035 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, rsp_x and rsp_id stable, req_ready=0000.
REQ-036 rst_n pulsed low during EXEC -> no rsp_valid; next grant goes to req0 even with req1..3 valid.
REQ-037 With ALU_SCHED_STATS_EN defined, 3 completed handshakes -> ops_done=3; reset -> ops_done=0.
